spi_slave: RTL
==============

Name: spi_slave

Overview:
SPI responder (mode 0: CPOL=0, CPHA=0, MSB first). It is the other end of the SPI master used by the RISC5 top level, so a board can answer an external SPI initiator. It sits on the RISC5 I/O bus as a memory-mapped device: the CPU writes a transmit word, reads the received word, and polls the ready flags. All SPI pins are asynchronous to clk and are oversampled; the SCLK frequency must not exceed clk/8.

Parameters:
W, 8, word length in bits (legal values 8..32).
FILL, all ones, word shifted out when the transmit buffer is empty.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous reset, active-low.
SCLK  input  1  SPI clock from the initiator (asynchronous).
SS  input  1  slave select, active-low (asynchronous).
MOSI  input  1  serial data from the initiator (asynchronous).
MISO  output  1  serial data to the initiator.
MISOen  output  1  MISO drive enable, for the pad IOBUF; 1 while SS is active (synchronised).
dataTx  input  W  transmit word from outbus.
load  input  1  one-cycle strobe: write dataTx into the transmit buffer.
txrdy  output  1  transmit buffer empty, can accept a load.
dataRx  output  W  last complete received word.
rdy  output  1  dataRx holds an unread word.
done  input  1  one-cycle strobe: CPU has read dataRx, clear rdy.
ovr  output  1  sticky overrun: a word completed while rdy=1. Cleared only by reset.

Behaviour:
- Reset (rst=0 at posedge clk): MISO=1, MISOen=0, txrdy=1, rdy=0, ovr=0, dataRx=0, bit counter=0, state IDLE, all synchronisers set to idle levels (SCLK=0, SS=1, MOSI=0).
- Synchronisation: SCLK, SS and MOSI each pass through 2 flops, plus one history flop on SCLK and SS for edge detection. Edge detection fires 3 clk cycles after the pin transition. MOSI is sampled from its synchronised copy in the same cycle as the detected SCLK rise.
- State IDLE: MISOen=0, MISO=1. On a detected SS fall, go to ACTIVE:
  - tx shift register = txbuf if txrdy=0, else FILL;
  - txrdy is set to 1;
  - bit counter = 0;
  - MISO = tx shift register MSB on the next cycle.
- State ACTIVE: MISOen=1.
  - On an SCLK rise: rx shift = {rx shift[W-2:0], MOSI}, and the bit counter increments.
  - On an SCLK fall: tx shift moves left by one and MISO takes the new MSB. Exception: no shift on the first fall after a word reload.
- Word completion, on the SCLK rise where the counter reaches W:
  - dataRx = the full received word; rdy = 1; ovr = 1 if rdy was already 1; counter = 0.
  - The tx shift register is reloaded from txbuf (txrdy becomes 1) or from FILL, and its MSB appears on MISO in the next cycle. This lets back-to-back words stream with no gap.
- Detected SS rise in any state: return to IDLE and set the counter to 0. A partial word is discarded: rdy and dataRx are unchanged, and a txbuf word that was already consumed is not restored.
- load: txbuf = dataTx and txrdy = 0 in the next cycle. If load coincides with a txbuf consume, the consume takes the old value and txrdy ends at 0 (holding the new word). A load while txrdy=0 overwrites txbuf.
- done: rdy = 0 in the next cycle. If done coincides with a word completion, rdy stays 1 and ovr is not set by that completion.
- SS and SCLK edges detected in the same cycle: the SS edge has priority and the SCLK edge is ignored.
- Reset takes effect mid-word: the transfer is aborted and every output returns to its reset value.

Test Plan:
- W=8, CPU loads 8'hA5, initiator sends 8'h3C at clk/8 → MISO bits 1,0,1,0,0,1,0,1; dataRx=8'h3C; rdy=1 exactly 1 cycle after the detected 8th rise; txrdy=1 after the SS fall.
- No load, initiator sends 8'h00 → MISO bits all 1 (FILL); dataRx=8'h00; rdy=1.
- Two back-to-back words 8'h11 then 8'h22 without reading, loads 8'h81 then 8'h42 → second MISO word is 8'h42; dataRx=8'h22; ovr=1.
- SS deasserted after 5 bits, then a new full word 8'hF0 → the first transfer produces no rdy; dataRx=8'hF0 after the second transfer; the counter restarts at 0.
- done pulsed in the same cycle as a word completion → rdy=1, ovr=0; a later done alone → rdy=0.
- W=32: word 32'hDEADBEEF in both directions → exact loopback; rst=0 applied at bit 17 of a following word → MISO=1, MISOen=0, rdy=0, ovr=0 on the next cycle.

Source files
------------

// File: rtl/spi_slave.sv
// Mode-0 SPI responder on the RISC5 I/O bus: the CPU loads a transmit word, reads the received word
// and polls txrdy/rdy/ovr. All SPI pins are oversampled, so SCLK must stay at or below clk/8.
module spi_slave #(
    parameter int W = 8,
    parameter logic [W-1:0] FILL = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         SCLK,
    input  logic         SS,
    input  logic         MOSI,
    output logic         MISO,
    output logic         MISOen,
    input  logic [W-1:0] dataTx,
    input  logic         load,
    output logic         txrdy,
    output logic [W-1:0] dataRx,
    output logic         rdy,
    input  logic         done,
    output logic         ovr
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t         state;
    logic           sclk1, sclk2, sclkh;
    logic           ss1, ss2, ssh;
    logic           mosi1, mosi2;
    logic [W-1:0]   txbuf;
    logic [W-2:0]   txrest;
    logic [W-2:0]   rxshift;
    logic [CW-1:0]  bitcnt;
    logic           skipfall;

    logic           sclkrise, sclkfall, ssrise, ssfall;
    logic           complete, consume;
    logic [W-1:0]   nextword;
    logic [W-1:0]   rxnext;

    assign sclkrise = sclk2 & ~sclkh;
    assign sclkfall = ~sclk2 & sclkh;
    assign ssrise   = ss2 & ~ssh;
    assign ssfall   = ~ss2 & ssh;

    // MISO holds the current MSB; txrest holds the bits still to be shifted out behind it.
    assign nextword = txrdy ? FILL : txbuf;
    assign rxnext   = {rxshift, mosi2};
    assign complete = (state == ACTIVE) && !ssrise && !ssfall && sclkrise
                      && (bitcnt == CW'(W - 1));
    assign consume  = ((state == IDLE) && ssfall) || complete;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            sclk1    <= 1'b0;
            sclk2    <= 1'b0;
            sclkh    <= 1'b0;
            ss1      <= 1'b1;
            ss2      <= 1'b1;
            ssh      <= 1'b1;
            mosi1    <= 1'b0;
            mosi2    <= 1'b0;
            MISO     <= 1'b1;
            MISOen   <= 1'b0;
            txbuf    <= '0;
            txrest   <= '1;
            rxshift  <= '0;
            bitcnt   <= '0;
            skipfall <= 1'b0;
            txrdy    <= 1'b1;
            dataRx   <= '0;
            rdy      <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            sclk1 <= SCLK;
            sclk2 <= sclk1;
            sclkh <= sclk2;
            ss1   <= SS;
            ss2   <= ss1;
            ssh   <= ss2;
            mosi1 <= MOSI;
            mosi2 <= mosi1;

            // A load landing on a consume keeps the new word pending.
            if (load) begin
                txbuf <= dataTx;
                txrdy <= 1'b0;
            end else if (consume) begin
                txrdy <= 1'b1;
            end

            if (done)
                rdy <= 1'b0;

            case (state)
                IDLE: begin
                    MISOen <= 1'b0;
                    MISO   <= 1'b1;
                    if (ssfall) begin
                        state    <= ACTIVE;
                        MISOen   <= 1'b1;
                        MISO     <= nextword[W-1];
                        txrest   <= nextword[W-2:0];
                        bitcnt   <= '0;
                        skipfall <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (ssrise) begin
                        state    <= IDLE;
                        MISOen   <= 1'b0;
                        MISO     <= 1'b1;
                        bitcnt   <= '0;
                        skipfall <= 1'b0;
                    end else if (!ssfall) begin
                        if (sclkrise) begin
                            rxshift <= rxnext[W-2:0];
                            if (complete) begin
                                bitcnt   <= '0;
                                dataRx   <= rxnext;
                                rdy      <= 1'b1;
                                if (!done)
                                    ovr <= ovr | rdy;
                                MISO     <= nextword[W-1];
                                txrest   <= nextword[W-2:0];
                                skipfall <= 1'b1;
                            end else begin
                                bitcnt <= bitcnt + 1'b1;
                            end
                        end else if (sclkfall) begin
                            // The fall closing a word must not push out the freshly reloaded MSB.
                            if (skipfall) begin
                                skipfall <= 1'b0;
                            end else begin
                                MISO   <= txrest[W-2];
                                txrest <= {txrest[W-3:0], 1'b1};
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
